// File: rtl/stream_pack_flush.sv
// Packs RATIO input words from a stream FIFO into one wide output beat.
// Supports partial-beat drain, flush of buffered data and sustained one-word-per-cycle throughput.
module stream_pack_flush #(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_empty_i,
    input  logic [IN_WIDTH-1:0]       in_data_i,
    output logic                      in_ready_o,
    input  logic                      drain_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [IN_WIDTH*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]          out_mask_o
);

    localparam int CW = $clog2(RATIO + 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IN_WIDTH*RATIO-1:0] acc_q, acc_d;
    logic [RATIO-1:0]          mask_q, mask_d;
    logic                      accept;
    logic                      fire;

    assign out_valid_o = (state_q == S_HOLD);
    assign in_ready_o  = !rst && !flush && (!out_valid_o || out_ready_i);
    assign accept      = in_ready_o && !in_empty_i;
    assign fire        = out_valid_o && out_ready_i;
    assign out_data_o  = acc_q;
    assign out_mask_o  = mask_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        if (flush) begin
            state_d = S_FILL;
            cnt_d   = '0;
            acc_d   = '0;
            mask_d  = '0;
        end else if (state_q == S_FILL) begin
            if (accept) begin
                for (int unsigned i = 0; i < RATIO; i++) begin
                    if (cnt_q == CW'(i)) begin
                        acc_d[i*IN_WIDTH +: IN_WIDTH] = in_data_i;
                        mask_d[i]                     = 1'b1;
                    end
                end
                if (cnt_q == CW'(RATIO - 1) || drain_i) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (drain_i && cnt_q != '0) begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        end else if (fire) begin
            // An accept in HOLD is only possible alongside fire; it seeds lane 0 of the next beat.
            state_d = S_FILL;
            cnt_d   = '0;
            acc_d   = '0;
            mask_d  = '0;
            if (accept) begin
                acc_d[IN_WIDTH-1:0] = in_data_i;
                mask_d[0]           = 1'b1;
                if (drain_i) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_stream_pack_flush.sv
// Scoreboard bench for stream_pack_flush (IN_WIDTH=8, RATIO=4) with a modelled upstream FIFO.
module tb_stream_pack_flush;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_empty_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic        drain_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_mask_o;

    logic [7:0]  fifo[$];
    beat_t       sb[$];
    logic        done;

    int          vectors;
    int          miscompares;
    int          cycles;
    logic        prev_clear;
    logic        prev_hold;
    logic [31:0] hold_d;
    logic [3:0]  hold_m;

    stream_pack_flush #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_empty_i  (in_empty_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .drain_i     (drain_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_mask_o  (out_mask_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard compare on each fire.
    initial begin
        vectors     = 0;
        miscompares = 0;
        cycles      = 0;
        prev_clear  = 1'b0;
        prev_hold   = 1'b0;
        hold_d      = '0;
        hold_m      = '0;
        forever begin
            @(negedge clk);
            cycles++;
            if (cycles > 6000) begin
                miscompares++;
                $display("FAIL timeout: got %0d cycles, expected completion", cycles);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
            chk("in_ready", {31'b0, in_ready_o},
                {31'b0, (!rst && !flush && (!out_valid_o || out_ready_i))});
            if (prev_clear) begin
                chk("clear_valid", {31'b0, out_valid_o}, 32'd0);
                chk("clear_mask", {28'b0, out_mask_o}, 32'd0);
                chk("clear_data", out_data_o, 32'd0);
            end
            if (prev_hold) begin
                chk("hold_valid", {31'b0, out_valid_o}, 32'd1);
                chk("hold_data", out_data_o, hold_d);
                chk("hold_mask", {28'b0, out_mask_o}, {28'b0, hold_m});
            end
            if (out_valid_o && out_ready_i && !rst && !flush) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_data_o, 32'hxxxx_xxxx);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_data", out_data_o, e.d);
                    chk("beat_mask", {28'b0, out_mask_o}, {28'b0, e.m});
                end
            end
            prev_clear = rst || flush;
            prev_hold  = out_valid_o && !out_ready_i && !rst && !flush;
            hold_d     = out_data_o;
            hold_m     = out_mask_o;
            if (done) begin
                chk("scoreboard_drained", sb.size(), 32'd0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

    task automatic refresh();
        in_empty_i = (fifo.size() == 0);
        in_data_i  = in_empty_i ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] m);
        sb.push_back({d, m});
    endtask

    // One clock: the pop decision is taken from settled pre-edge values.
    task automatic tick();
        logic p;
        @(negedge clk);
        p = in_ready_o && !in_empty_i;
        @(posedge clk);
        #1;
        if (p) void'(fifo.pop_front());
        refresh();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && fifo.size() != 0; i++) tick();
    endtask

    initial begin
        done        = 1'b0;
        rst         = 1'b1;
        flush       = 1'b0;
        drain_i     = 1'b0;
        out_ready_i = 1'b1;
        refresh();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Full beat, lane 0 in the LSBs
        expect_beat(32'h4433_2211, 4'hF);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_empty();
        repeat (3) tick();

        // Partial beat via drain with FIFO empty
        expect_beat(32'h0000_A2A1, 4'h3);
        push(8'hA1); push(8'hA2);
        wait_empty();
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        repeat (3) tick();

        // Backpressure holds the beat; release fires it and pops the next word into lane 0
        out_ready_i = 1'b0;
        expect_beat(32'hB4B3_B2B1, 4'hF);
        expect_beat(32'h0000_00C1, 4'h1);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hC1);
        repeat (10) tick();
        out_ready_i = 1'b1;
        tick();
        drain_i = 1'b1;
        tick();
        drain_i = 1'b0;
        repeat (3) tick();

        // Fire, accept and drain together give an immediate 1-lane beat
        out_ready_i = 1'b0;
        expect_beat(32'hD4D3_D2D1, 4'hF);
        expect_beat(32'h0000_00D5, 4'h1);
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5);
        repeat (6) tick();
        out_ready_i = 1'b1;
        drain_i     = 1'b1;
        tick();
        drain_i = 1'b0;
        repeat (3) tick();

        // Continuous 12-word stream
        expect_beat(32'h0403_0201, 4'hF);
        expect_beat(32'h0807_0605, 4'hF);
        expect_beat(32'h0C0B_0A09, 4'hF);
        for (int i = 1; i <= 12; i++) push(8'(i));
        wait_empty();
        repeat (3) tick();

        // Flush with drain and a non-empty FIFO discards the partial beat and pops nothing
        push(8'hF1); push(8'hF2); push(8'hF3);
        wait_empty();
        expect_beat(32'h5453_5251, 4'hF);
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        flush   = 1'b1;
        drain_i = 1'b1;
        tick();
        flush   = 1'b0;
        drain_i = 1'b0;
        wait_empty();
        repeat (3) tick();

        // Reset while holding a beat under backpressure drops it
        out_ready_i = 1'b0;
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        wait_empty();
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        out_ready_i = 1'b1;
        expect_beat(32'h7473_7271, 4'hF);
        push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        wait_empty();
        repeat (5) tick();

        done = 1'b1;
    end

endmodule
